irq_enc_16x4: RTL and testbench

- Sequential 16-to-4 priority encoder: the encoding counterpart to the 4x16 one-hot decoder.
- Captures request pulses on 16 lines into a pending register.
- Presents the highest-priority pending index as a 4-bit code on a valid/ready handshake, and retires that bit when the consumer accepts it.
- Sits between event sources and the downstream dispatch logic; its 4-bit output can drive a dec_4x16 to regenerate a one-hot acknowledge.

---
 rtl/irq_enc_16x4_pkg.sv | 28 ++
 rtl/irq_enc_16x4_if.sv | 33 +++
 rtl/irq_enc_16x4_prio_enc.sv | 38 +++
 rtl/irq_enc_16x4.sv | 118 +++++++++++
 tb/tb_irq_enc_16x4.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/irq_enc_16x4_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_enc_16x4_pkg                                                      |
// | Shared defaults, state encoding and the one-hot helper used by the    |
// | 16-to-4 sequential priority encoder.                                  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package irq_enc_16x4_pkg;

  localparam int c_N         = 16;  // request lines
  localparam int c_W         = 4;   // index width, clog2(c_N)
  localparam int c_PRIO_HIGH = 1;   // 1: highest index wins

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Expand an index into the mask of the single line it names.
  function automatic logic [c_N-1:0] onehot(input logic [c_W-1:0] idx);
    logic [c_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_enc_16x4_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_enc_16x4_if                                                       |
// | Valid/ready grant channel carrying the encoded request index.         |
// |   out       : encoded index (master -> slave)                         |
// |   out_valid : out holds a valid index (master -> slave)               |
// |   out_ready : consumer accepts out this cycle (slave -> master)       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface irq_enc_16x4_if
  import irq_enc_16x4_pkg::*;
#(
  parameter int W = c_W
);

  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output out,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out,
    input  out_valid,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/irq_enc_16x4_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_enc_16x4_prio_enc                                                 |
// | Combinational priority encoder.                                       |
// |   vector : N-bit request vector (in)                                  |
// |   idx    : index of the winning set bit, 0 when none (out)            |
// |   any    : at least one bit of vector is set (out)                    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module irq_enc_16x4_prio_enc
  import irq_enc_16x4_pkg::*;
#(
  parameter int N         = c_N,
  parameter int W         = c_W,
  parameter int PRIO_HIGH = c_PRIO_HIGH
) (
  input  logic [N-1:0] vector,
  output logic [W-1:0] idx,
  output logic         any
);

  // The scan runs towards the winning end so the last hit overwrites idx.
  always_comb begin
    idx = '0;
    any = |vector;
    if (PRIO_HIGH != 0) begin
      for (int k = 0; k < N; k++) begin
        if (vector[k]) idx = W'(k);
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (vector[k]) idx = W'(k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/irq_enc_16x4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_enc_16x4                                                          |
// | Sequential 16-to-4 priority encoder: request pulses are collected in  |
// | a pending register and the winning index is offered on a valid/ready |
// | channel; the accepted bit is retired.                                 |
// |   clk      : rising-edge clock                                        |
// |   rst      : synchronous active-high reset                            |
// |   en       : gates request capture and new grants                     |
// |   in       : N request pulse lines                                    |
// |   bus      : grant channel (out / out_valid / out_ready)              |
// |   pending  : registered pending-request vector                        |
// |   overflow : sticky, a request pulse hit an already pending line      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module irq_enc_16x4
  import irq_enc_16x4_pkg::*;
#(
  parameter int N         = c_N,
  parameter int W         = c_W,
  parameter int PRIO_HIGH = c_PRIO_HIGH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [N-1:0]   in,
  irq_enc_16x4_if.master bus,
  output logic [N-1:0]   pending,
  output logic           overflow
);

  state_t         r_state;
  logic [N-1:0]   r_pending;
  logic [W-1:0]   r_out;
  logic           r_valid;
  logic           r_overflow;

  logic           w_accept;
  logic [N-1:0]   w_clr;
  logic [N-1:0]   w_rem;
  logic [N-1:0]   w_set;
  logic [W-1:0]   w_idx_pend;
  logic           w_any_pend;
  logic [W-1:0]   w_idx_rem;
  logic           w_any_rem;

  assign w_accept = r_valid & bus.out_ready;
  assign w_clr    = w_accept ? onehot(r_out) : '0;
  // rem deliberately excludes same-cycle requests; they are seen next load.
  assign w_rem    = r_pending & ~w_clr;
  assign w_set    = en ? in : '0;

  irq_enc_16x4_prio_enc #(
    .N         (N),
    .W         (W),
    .PRIO_HIGH (PRIO_HIGH)
  ) u_enc_pend (
    .vector (r_pending),
    .idx    (w_idx_pend),
    .any    (w_any_pend)
  );

  irq_enc_16x4_prio_enc #(
    .N         (N),
    .W         (W),
    .PRIO_HIGH (PRIO_HIGH)
  ) u_enc_rem (
    .vector (w_rem),
    .idx    (w_idx_rem),
    .any    (w_any_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_out      <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      // Set wins over clear: a pulse on the line being retired re-pends it.
      r_pending <= w_rem | w_set;
      if (|(w_set & w_rem)) r_overflow <= 1'b1;

      case (r_state)
        IDLE: begin
          if (en && w_any_pend) begin
            r_out   <= w_idx_pend;
            r_valid <= 1'b1;
            r_state <= PRESENT;
          end
        end
        PRESENT: begin
          // Held index is never preempted; only an accept moves it on.
          if (w_accept) begin
            if (en && w_any_rem) begin
              r_out <= w_idx_rem;
            end else begin
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_valid;
  assign pending       = r_pending;
  assign overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_irq_enc_16x4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_irq_enc_16x4                                                       |
// | Self-checking bench for irq_enc_16x4. Expected grant indices are      |
// | queued as stimulus is applied and consumed whenever the DUT hands an  |
// | index over on the valid/ready channel.                                |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_irq_enc_16x4;

  localparam int N         = 16;
  localparam int W         = 4;
  localparam int PRIO_HIGH = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [N-1:0] in;
  logic [N-1:0] pending;
  logic         overflow;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] seq[4];

  irq_enc_16x4_if #(.W(W)) bus_if ();

  irq_enc_16x4 #(
    .N         (N),
    .W         (W),
    .PRIO_HIGH (PRIO_HIGH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in       (in),
    .bus      (bus_if),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] v);
    in = v;
    step();
    in = '0;
  endtask

  // Scoreboard consumer: a handshake seen mid-cycle completes on the next edge.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
      if (exp_q.size() == 0) check("grant_unexpected", 32'(bus_if.out), 32'hDEAD);
      else                   check("grant", 32'(bus_if.out), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    rst              = 1'b1;
    en               = 1'b1;
    in               = '1;
    bus_if.out_ready = 1'b1;

    // Reset holds everything at zero even with every request line high.
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_pending",  32'(pending),          32'h0);
      check("rst_valid",    32'(bus_if.out_valid), 32'h0);
      check("rst_out",      32'(bus_if.out),       32'h0);
      check("rst_overflow", 32'(overflow),         32'h0);
    end
    rst = 1'b0;
    in  = '0;
    step();

    // Single request: pending after one edge, grant after two, then retired.
    exp_q.push_back(4'd4);
    pulse(16'h0010);
    check("single_pending", 32'(pending),          32'h0010);
    check("single_valid0",  32'(bus_if.out_valid), 32'h0);
    step();
    check("single_valid1",  32'(bus_if.out_valid), 32'h1);
    check("single_out",     32'(bus_if.out),       32'h4);
    step();
    check("single_done",    32'(bus_if.out_valid), 32'h0);
    check("single_clear",   32'(pending),          32'h0);

    // Back-to-back grants without bubbles.
    if (PRIO_HIGH != 0) begin
      seq[0] = 4'd15; seq[1] = 4'd10; seq[2] = 4'd5;  seq[3] = 4'd0;
    end else begin
      seq[0] = 4'd0;  seq[1] = 4'd5;  seq[2] = 4'd10; seq[3] = 4'd15;
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(seq[i]);
    pulse(16'h8421);
    check("b2b_pending", 32'(pending), 32'h8421);
    for (int i = 0; i < 4; i++) begin
      step();
      check("b2b_valid", 32'(bus_if.out_valid), 32'h1);
      check("b2b_out",   32'(bus_if.out),       32'(seq[i]));
    end
    step();
    check("b2b_idle",  32'(bus_if.out_valid), 32'h0);
    check("b2b_clear", 32'(pending),          32'h0);

    // Stall: held index is not preempted by a later higher request.
    bus_if.out_ready = 1'b0;
    pulse(16'h0004);
    step();
    check("stall_valid", 32'(bus_if.out_valid), 32'h1);
    check("stall_out",   32'(bus_if.out),       32'h2);
    pulse(16'h0100);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", 32'(bus_if.out), 32'h2);
    end
    check("stall_pending", 32'(pending), 32'h0104);
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd8);
    bus_if.out_ready = 1'b1;
    step();
    check("stall_next_valid", 32'(bus_if.out_valid), 32'h1);
    check("stall_next_out",   32'(bus_if.out),       32'h8);
    step();
    check("stall_idle",       32'(bus_if.out_valid), 32'h0);
    check("stall_clear",      32'(pending),          32'h0);

    // Overflow: second pulse on an unaccepted line; sticky until reset.
    bus_if.out_ready = 1'b0;
    pulse(16'h0002);
    check("ovf_before", 32'(overflow), 32'h0);
    step();
    pulse(16'h0002);
    check("ovf_set",     32'(overflow), 32'h1);
    check("ovf_pending", 32'(pending),  32'h0002);
    step();
    check("ovf_sticky",  32'(overflow), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("ovf_rst",       32'(overflow),         32'h0);
    check("ovf_rst_valid", 32'(bus_if.out_valid), 32'h0);
    check("ovf_rst_pend",  32'(pending),          32'h0);

    // Pulse on the line being accepted re-pends it without overflow.
    pulse(16'h0002);
    step();
    check("repend_out", 32'(bus_if.out), 32'h1);
    exp_q.push_back(4'd1);
    in               = 16'h0002;
    bus_if.out_ready = 1'b1;
    step();
    in               = '0;
    bus_if.out_ready = 1'b0;
    check("repend_ovf",     32'(overflow),         32'h0);
    check("repend_pending", 32'(pending),          32'h0002);
    check("repend_bubble",  32'(bus_if.out_valid), 32'h0);
    exp_q.push_back(4'd1);
    bus_if.out_ready = 1'b1;
    step();
    check("repend_valid",   32'(bus_if.out_valid), 32'h1);
    check("repend_out2",    32'(bus_if.out),       32'h1);
    step();
    check("repend_idle",    32'(bus_if.out_valid), 32'h0);
    check("repend_clear",   32'(pending),          32'h0);

    // en=0 keeps the presented index and ignores new requests.
    bus_if.out_ready = 1'b0;
    pulse(16'h0008);
    step();
    check("en0_out", 32'(bus_if.out), 32'h3);
    en = 1'b0;
    step();
    check("en0_valid",   32'(bus_if.out_valid), 32'h1);
    check("en0_hold",    32'(bus_if.out),       32'h3);
    pulse(16'h0080);
    check("en0_ignore",  32'(pending),          32'h0008);
    step();
    check("en0_hold2",   32'(bus_if.out),       32'h3);
    exp_q.push_back(4'd3);
    bus_if.out_ready = 1'b1;
    step();
    check("en0_idle",    32'(bus_if.out_valid), 32'h0);
    check("en0_clear",   32'(pending),          32'h0);
    check("en0_out_ret", 32'(bus_if.out),       32'h3);
    bus_if.out_ready = 1'b0;
    en = 1'b1;
    step();

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
